// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit that owns HI/LO for the MIPS pipeline.
// Multiply is counter-gated over MUL_LAT edges; divide is restoring radix-2 plus one fixup edge.
module muldiv_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             op_ready,
  output logic             busy,
  output logic             hilo_stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // Handshake: an op transfers on a rising edge where op_valid && op_ready && !flush;
  // op_ready is ~busy, so the issuer holds op_valid and operands until that edge.
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  localparam int CW = $clog2(WIDTH + MUL_LAT + 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             op_signed;
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH-1:0] r_reg;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [2*WIDTH-1:0] mul_a_ext;
  logic [2*WIDTH-1:0] mul_b_ext;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  assign op_ready   = ~busy;
  assign hilo_stall = busy;

  always_comb begin
    a_neg     = ~op[0] & src_a[WIDTH-1];
    b_neg     = ~op[0] & src_b[WIDTH-1];
    a_mag     = a_neg ? (~src_a + 1'b1) : src_a;
    b_mag     = b_neg ? (~src_b + 1'b1) : src_b;
    mul_a_ext = op_signed ? {{WIDTH{a_reg[WIDTH-1]}}, a_reg} : {{WIDTH{1'b0}}, a_reg};
    mul_b_ext = op_signed ? {{WIDTH{b_reg[WIDTH-1]}}, b_reg} : {{WIDTH{1'b0}}, b_reg};
    product   = mul_a_ext * mul_b_ext;
    // Partial remainder stays below 2*divisor, so bit WIDTH of trial is the borrow.
    rem_shift = {r_reg, q_reg[WIDTH-1]};
    trial     = rem_shift - {1'b0, d_reg};
    q_fix     = neg_q ? (~q_reg + 1'b1) : q_reg;
    r_fix     = neg_r ? (~r_reg + 1'b1) : r_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      op_signed <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      q_reg     <= '0;
      d_reg     <= '0;
      r_reg     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (op_valid && !flush) begin
            op_signed <= ~op[0];
            a_reg     <= src_a;
            b_reg     <= src_b;
            q_reg     <= a_mag;
            d_reg     <= b_mag;
            r_reg     <= '0;
            neg_q     <= a_neg ^ b_neg;
            neg_r     <= a_neg;
            cnt       <= '0;
            busy      <= 1'b1;
            state     <= op[1] ? DIV : MUL;
          end
        end
        MUL: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else if (cnt == CW'(MUL_LAT - 1)) begin
            {hi, lo} <= product;
            done     <= 1'b1;
            busy     <= 1'b0;
            cnt      <= '0;
            state    <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DIV: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else if (cnt == CW'(WIDTH)) begin
            // Divide by zero leaves the dividend in HI and all ones in LO.
            if (d_reg == '0) begin
              lo <= '1;
              hi <= a_reg;
            end else begin
              lo <= q_fix;
              hi <= r_fix;
            end
            done  <= 1'b1;
            busy  <= 1'b0;
            cnt   <= '0;
            state <= IDLE;
          end else begin
            if (!trial[WIDTH]) begin
              r_reg <= trial[WIDTH-1:0];
              q_reg <= {q_reg[WIDTH-2:0], 1'b1};
            end else begin
              r_reg <= rem_shift[WIDTH-1:0];
              q_reg <= {q_reg[WIDTH-2:0], 1'b0};
            end
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: each op's HI/LO is checked against
// hand-computed values, along with busy length, done pulses, flush and reset.
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         op_valid;
  logic [1:0]   op;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic         flush;
  logic         op_ready;
  logic         busy;
  logic         hilo_stall;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] exp_q[$];

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  muldiv_unit #(.WIDTH(W), .MUL_LAT(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .op_valid   (op_valid),
    .op         (op),
    .src_a      (src_a),
    .src_b      (src_b),
    .flush      (flush),
    .op_ready   (op_ready),
    .busy       (busy),
    .hilo_stall (hilo_stall),
    .done       (done),
    .hi         (hi),
    .lo         (lo)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask

  // Issue one op, wait for completion, check result, busy length and done count.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [2*W-1:0] exp_hilo,
                        input int exp_busy);
    int busy_cyc;
    int done_cnt;
    logic [2*W-1:0] exp_v;
    exp_q.push_back(exp_hilo);
    @(negedge clk);
    op_valid = 1'b1;
    op       = o;
    src_a    = a;
    src_b    = b;
    @(negedge clk);
    op_valid = 1'b0;
    busy_cyc = 0;
    done_cnt = 0;
    while (busy && busy_cyc < 200) begin
      busy_cyc++;
      done_cnt += int'(done);
      @(negedge clk);
    end
    done_cnt += int'(done);
    exp_v = exp_q.pop_front();
    check({tag, "_hilo"}, {hi, lo}, exp_v);
    @(negedge clk);
    done_cnt += int'(done);
    check({tag, "_busy_cycles"}, 64'(busy_cyc), 64'(exp_busy));
    check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
  endtask

  int done_cnt;

  initial begin
    rst      = 1'b0;
    op_valid = 1'b0;
    op       = 2'b00;
    src_a    = '0;
    src_b    = '0;
    flush    = 1'b0;

    // 1: reset
    do_reset(2);
    check("rst_hi", 64'(hi), 64'h0);
    check("rst_lo", 64'(lo), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_done", 64'(done), 64'h0);
    check("rst_op_ready", 64'(op_ready), 64'h1);
    check("rst_stall", 64'(hilo_stall), 64'h0);

    // 2-5: multiply and divide vectors
    run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 3);
    run_op("mult_m3x5", OP_MULT,  32'hFFFFFFFD, 32'h00000005, 64'hFFFFFFFF_FFFFFFF1, 3);
    run_op("multu_m3x5", OP_MULTU, 32'hFFFFFFFD, 32'h00000005, 64'h00000004_FFFFFFF1, 3);
    run_op("div_m7d2",  OP_DIV,   32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 33);
    run_op("div_7dm2",  OP_DIV,   32'h00000007, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33);
    run_op("divu_100d7", OP_DIVU, 32'd100,      32'd7,        64'h00000002_0000000E, 33);
    run_op("divu_big",  OP_DIVU,  32'hFFFFFFF9, 32'h00000002, 64'h00000001_7FFFFFFC, 33);
    run_op("divu_7d0",  OP_DIVU,  32'h00000007, 32'h00000000, 64'h00000007_FFFFFFFF, 33);
    run_op("div_m5d0",  OP_DIV,   32'hFFFFFFFB, 32'h00000000, 64'hFFFFFFFB_FFFFFFFF, 33);
    run_op("div_ovf",   OP_DIV,   32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33);

    // 5: back-to-back held op; operand change while busy must be ignored
    @(negedge clk);
    op_valid = 1'b1; op = OP_MULTU; src_a = 32'd2; src_b = 32'd3;
    @(negedge clk);
    check("b2b_busy_e0", 64'(busy), 64'h1);
    src_a = 32'd4; src_b = 32'd5;
    repeat (2) @(negedge clk);
    check("b2b_hilo_hold", {hi, lo}, 64'h00000000_80000000);
    @(negedge clk);
    check("b2b_first", {hi, lo}, 64'd6);
    check("b2b_first_done", 64'(done), 64'h1);
    check("b2b_first_idle", 64'(busy), 64'h0);
    @(negedge clk);
    check("b2b_second_accept", 64'(busy), 64'h1);
    check("b2b_done_drop", 64'(done), 64'h0);
    op_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("b2b_second", {hi, lo}, 64'd20);
    check("b2b_second_done", 64'(done), 64'h1);

    // 6: flush mid-divide keeps HI/LO and gives no done
    @(negedge clk);
    op_valid = 1'b1; op = OP_DIVU; src_a = 32'd100; src_b = 32'd7;
    @(negedge clk);
    op_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("flush_busy_before", 64'(busy), 64'h1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy_after", 64'(busy), 64'h0);
    check("flush_hilo", {hi, lo}, 64'd20);
    done_cnt = 0;
    repeat (40) begin
      done_cnt += int'(done);
      @(negedge clk);
    end
    check("flush_no_done", 64'(done_cnt), 64'h0);
    check("flush_hilo_late", {hi, lo}, 64'd20);

    // flush together with op_valid in IDLE: not accepted
    op_valid = 1'b1; flush = 1'b1; op = OP_MULT; src_a = 32'd9; src_b = 32'd9;
    @(negedge clk);
    op_valid = 1'b0; flush = 1'b0;
    check("flush_idle_reject", 64'(busy), 64'h0);

    // op_valid pulse during a divide is ignored: one done, divide result
    @(negedge clk);
    op_valid = 1'b1; op = OP_DIV; src_a = 32'hFFFFFFF9; src_b = 32'd2;
    @(negedge clk);
    op_valid = 1'b0;
    done_cnt = 0;
    repeat (4) @(negedge clk);
    op_valid = 1'b1; op = OP_MULTU; src_a = 32'd11; src_b = 32'd11;
    @(negedge clk);
    op_valid = 1'b0;
    repeat (60) begin
      done_cnt += int'(done);
      @(negedge clk);
    end
    check("ignore_done_count", 64'(done_cnt), 64'h1);
    check("ignore_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);

    // reset mid-op clears HI/LO and aborts
    @(negedge clk);
    op_valid = 1'b1; op = OP_MULTU; src_a = 32'd3; src_b = 32'd3;
    @(negedge clk);
    op_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_busy", 64'(busy), 64'h0);
    check("rst_mid_hilo", {hi, lo}, 64'h0);
    repeat (5) @(negedge clk);
    check("rst_mid_no_result", {hi, lo}, 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
